tt_loader_seq: RTL and testbench
================================

// Module: tt_loader_seq
// PURPOSE
//  Byte-serial program loader and run controller for the Tiny Tapeout RISC-V core.
//  Host drives a byte on ui_in and pulses uio_in[0] once per byte; this block decodes commands,
//  writes 32-bit words into the core's instruction memory, and controls core reset/run.
//  Sits inside tt_um_riscv_core_top between the pad nets and the core/imem.
// PARAMETERS
//  IMEM_AW      4   imem address width; capacity 2**IMEM_AW words
//  SYNC_STAGES  2   synchronizer flops on byte_stb (>=2)
// PORTS
//  clk          in   1        system clock
//  rst_n        in   1        asynchronous active-low reset
//  ena          in   1        tile enable; 0 => strobes ignored, state held
//  byte_in      in   8        host data byte (ui_in); stable while byte_stb high
//  byte_stb     in   1        host byte strobe (uio_in[0]), asynchronous
//  imem_we      out  1        imem write pulse, one cycle
//  imem_addr    out  IMEM_AW  imem word address
//  imem_wdata   out  32       imem write data
//  core_rst_n   out  1        core reset, active-low; high only in RUN/HALT
//  core_ce      out  1        core clock enable
//  core_halt    in   1        core reached halt (ebreak); level
//  state_o      out  2        0 IDLE, 1 LOAD, 2 RUN, 3 HALT
//  err          out  1        sticky protocol error
// BEHAVIOUR
//  Reset: state IDLE; imem_we=0, imem_addr=0, imem_wdata=0, core_rst_n=0, core_ce=0, err=0.
//  Strobe: byte_stb through SYNC_STAGES flops, rising-edge detect; byte captured on the edge-detect
//   cycle (3rd clk edge after byte_stb rises, SYNC_STAGES=2). One byte per strobe; high level never repeats.
//  Commands (IDLE only): 0x4C 'L' load; 0x52 'R' run; 0x53 'S' stop (valid in RUN/HALT).
//  LOAD: next byte N; N=0 or N>2**IMEM_AW => err=1, back to IDLE. Then 4*N bytes, little-endian
//   per word; on the 4th byte imem_we pulses next cycle with imem_addr=word index (0..N-1).
//   After word N-1 written => IDLE. byte counter 2 bits, word counter IMEM_AW+1 bits, no wrap.
//  RUN: 'R' in IDLE => RUN; core_rst_n rises the following cycle, core_ce=1 continuously.
//  core_halt=1 in RUN => HALT next cycle; core_ce=0, core_rst_n stays 1 (regs observable).
//  'S' in RUN or HALT => IDLE; core_rst_n=0 and core_ce=0 the following cycle.
//  Any other byte in IDLE, or non-'S' byte in RUN/HALT => err=1, state unchanged.
//  err clears on next accepted valid command byte in IDLE.
//  ena=0: edge detector still tracks but captured bytes are discarded; FSM, counters, outputs held.
//  Simultaneous core_halt and 'S' in RUN: 'S' wins => IDLE.
//  rst_n low mid-LOAD: partial word discarded, imem contents untouched, IDLE.
// CONFIGURATION
//  LOADSEQ_STEP_EN defined: command 0x54 'T' accepted in IDLE or HALT; from IDLE releases core_rst_n
//   and enters HALT; in HALT pulses core_ce for exactly one cycle (core_halt re-check skipped that cycle).
//  Undefined: 'T' is an unknown command (err=1); core_ce identical to (state==RUN).
// STRUCTURE
//  Package tt_loader_pkg: state enum (IDLE/LOAD/RUN/HALT), command byte constants
//   CMD_LOAD/CMD_RUN/CMD_STOP/CMD_STEP.
//  Sub-module tt_strobe_sync: SYNC_STAGES synchronizer + rising-edge detect -> one-cycle byte_vld.
//  FSM, byte/word counters and 32-bit shift-assembly register in this module.
// TESTING
//  1 Reset 10 cycles -> all outputs at reset values, state_o=0, core_rst_n=0.
//  2 Send 4C,02,13,05,10,00,73,00,10,00 -> imem_we at addr0 data 0x00100513,
//    addr1 data 0x00100073; state_o back to 0; err=0.
//  3 Send 4C,00 -> err=1, state_o=0, no imem_we; then 52 -> err=0, state_o=2, core_rst_n=1 next cycle.
//  4 In RUN raise core_halt -> state_o=3, core_ce=0; send 53 -> state_o=0, core_rst_n=0.
//  5 Hold byte_stb high 20 cycles -> exactly one byte accepted; ena=0 with strobe -> no state change.
//  6 LOADSEQ_STEP_EN: 54 from IDLE -> HALT, core_rst_n=1; 54 again -> core_ce high exactly 1 cycle.

Source files
------------

// File: rtl/tt_loader_pkg.sv
// Shared types and command bytes for the Tiny Tapeout program loader.
// Optional single-step command is enabled by LOADSEQ_STEP_EN.
package tt_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } state_e;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_RUN  = 8'h52;
  localparam logic [7:0] CMD_STOP = 8'h53;
  localparam logic [7:0] CMD_STEP = 8'h54;

endpackage

// File: rtl/tt_strobe_sync.sv
// Synchronizes the asynchronous host byte strobe and emits a
// one-cycle valid on its rising edge.
module tt_strobe_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic byte_stb,
  output logic byte_vld
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], byte_stb};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign byte_vld = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/tt_loader_seq.sv
// Byte-serial program loader and core run controller.
// Define LOADSEQ_STEP_EN to accept the 'T' single-step command.
module tt_loader_seq
  import tt_loader_pkg::*;
#(
  parameter int IMEM_AW     = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [7:0]         byte_in,
  input  logic               byte_stb,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_wdata,
  output logic               core_rst_n,
  output logic               core_ce,
  input  logic               core_halt,
  output logic [1:0]         state_o,
  output logic               err
);

  localparam logic [8:0] NMAX = 9'(2**IMEM_AW);

  logic byte_vld;

  tt_strobe_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .byte_stb(byte_stb),
    .byte_vld(byte_vld)
  );

  state_e             state_q;
  logic               have_n_q;
  logic [IMEM_AW:0]   n_q;
  logic [IMEM_AW:0]   word_cnt_q;
  logic [1:0]         byte_cnt_q;
  logic [23:0]        sh_q;
  logic               we_q;
  logic [IMEM_AW-1:0] addr_q;
  logic [31:0]        wdata_q;
  logic               crst_q;
  logic               ce_q;
  logic               err_q;

  logic               vld;
  logic               n_ok;
  logic [IMEM_AW:0]   wcnt_nxt;

  assign vld      = byte_vld & ena;
  assign n_ok     = (byte_in != 8'd0) && ({1'b0, byte_in} <= NMAX);
  assign wcnt_nxt = word_cnt_q + (IMEM_AW+1)'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      have_n_q   <= 1'b0;
      n_q        <= '0;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      sh_q       <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      crst_q     <= 1'b0;
      ce_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      we_q <= 1'b0;
      if (ena) begin
`ifdef LOADSEQ_STEP_EN
        // step pulse lasts a single cycle
        if (state_q == ST_HALT) ce_q <= 1'b0;
`endif
        unique case (state_q)
          ST_IDLE: begin
            if (vld) begin
              if (byte_in == CMD_LOAD) begin
                state_q  <= ST_LOAD;
                have_n_q <= 1'b0;
                err_q    <= 1'b0;
              end else if (byte_in == CMD_RUN) begin
                state_q <= ST_RUN;
                crst_q  <= 1'b1;
                ce_q    <= 1'b1;
                err_q   <= 1'b0;
`ifdef LOADSEQ_STEP_EN
              end else if (byte_in == CMD_STEP) begin
                state_q <= ST_HALT;
                crst_q  <= 1'b1;
                ce_q    <= 1'b0;
                err_q   <= 1'b0;
`endif
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          ST_LOAD: begin
            if (vld) begin
              if (!have_n_q) begin
                if (n_ok) begin
                  have_n_q   <= 1'b1;
                  n_q        <= byte_in[IMEM_AW:0];
                  word_cnt_q <= '0;
                  byte_cnt_q <= '0;
                end else begin
                  err_q   <= 1'b1;
                  state_q <= ST_IDLE;
                end
              end else begin
                sh_q       <= {byte_in, sh_q[23:8]};
                byte_cnt_q <= byte_cnt_q + 2'd1;
                if (byte_cnt_q == 2'd3) begin
                  we_q       <= 1'b1;
                  addr_q     <= word_cnt_q[IMEM_AW-1:0];
                  wdata_q    <= {byte_in, sh_q};
                  word_cnt_q <= wcnt_nxt;
                  if (wcnt_nxt == n_q) state_q <= ST_IDLE;
                end
              end
            end
          end
          ST_RUN: begin
            // stop takes priority over a concurrent halt
            if (vld && byte_in == CMD_STOP) begin
              state_q <= ST_IDLE;
              crst_q  <= 1'b0;
              ce_q    <= 1'b0;
            end else begin
              if (vld) err_q <= 1'b1;
              if (core_halt) begin
                state_q <= ST_HALT;
                ce_q    <= 1'b0;
              end
            end
          end
          ST_HALT: begin
            if (vld) begin
              if (byte_in == CMD_STOP) begin
                state_q <= ST_IDLE;
                crst_q  <= 1'b0;
                ce_q    <= 1'b0;
`ifdef LOADSEQ_STEP_EN
              end else if (byte_in == CMD_STEP) begin
                ce_q <= 1'b1;
`endif
              end else begin
                err_q <= 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign core_rst_n = crst_q;
  assign core_ce    = ce_q;
  assign state_o    = state_q;
  assign err        = err_q;

endmodule

// File: tb/tb_tt_loader_seq.sv
// Randomized scoreboard bench for tt_loader_seq against a
// byte-level reference model of the loader protocol.
module tb_tt_loader_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b1;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_stb = 1'b0;
  logic        imem_we;
  logic [3:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        core_rst_n;
  logic        core_ce;
  logic        core_halt = 1'b0;
  logic [1:0]  state_o;
  logic        err;

  tt_loader_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .byte_in   (byte_in),
    .byte_stb  (byte_stb),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .core_rst_n(core_rst_n),
    .core_ce   (core_ce),
    .core_halt (core_halt),
    .state_o   (state_o),
    .err       (err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [35:0] exp_q[$];

  // reference model: mode 0 idle, 1 load, 2 run, 3 halt
  int          m_mode = 0;
  bit          m_err = 0;
  bit          m_need_n = 0;
  int          m_nwords = 0;
  int          m_widx = 0;
  logic [7:0]  m_bytes[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && imem_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %08h expected none",
                 imem_addr, imem_wdata);
      end else begin
        logic [35:0] e;
        e = exp_q.pop_front();
        if ({imem_addr, imem_wdata} !== e) begin
          errors++;
          $display("FAIL imem_write: got %0h/%08h expected %0h/%08h",
                   imem_addr, imem_wdata, e[35:32], e[31:0]);
        end
      end
    end
  end

`ifdef LOADSEQ_STEP_EN
  int ce_cnt = 0;
  always @(negedge clk) if (core_ce && state_o == 2'd3) ce_cnt++;
`endif

  function automatic bit is_step_cmd(logic [7:0] b);
`ifdef LOADSEQ_STEP_EN
    return b == 8'h54;
`else
    return 1'b0;
`endif
  endfunction

  function automatic void model_reset();
    m_mode = 0;
    m_err = 0;
    m_need_n = 0;
    m_bytes.delete();
  endfunction

  function automatic void model_byte(logic [7:0] b);
    case (m_mode)
      0: begin
        if (b == 8'h4C) begin
          m_mode = 1; m_err = 0; m_need_n = 1;
        end else if (b == 8'h52) begin
          m_mode = 2; m_err = 0;
        end else if (is_step_cmd(b)) begin
          m_mode = 3; m_err = 0;
        end else m_err = 1;
      end
      1: begin
        if (m_need_n) begin
          if (b == 0 || b > 16) begin
            m_err = 1; m_mode = 0;
          end else begin
            m_nwords = b; m_widx = 0; m_need_n = 0;
            m_bytes.delete();
          end
        end else begin
          m_bytes.push_back(b);
          if (m_bytes.size() == 4) begin
            logic [31:0] w;
            w = m_bytes[0] + (m_bytes[1] << 8) + (m_bytes[2] << 16)
              + (m_bytes[3] << 24);
            exp_q.push_back({4'(m_widx), w});
            m_widx++;
            m_bytes.delete();
            if (m_widx == m_nwords) m_mode = 0;
          end
        end
      end
      default: begin
        if (b == 8'h53) m_mode = 0;
        else if (!(m_mode == 3 && is_step_cmd(b))) m_err = 1;
      end
    endcase
  endfunction

  task automatic check_outputs(string tag);
    chk({tag, ".state"}, 32'(state_o), 32'(m_mode));
    chk({tag, ".err"}, 32'(err), 32'(m_err));
    chk({tag, ".core_rst_n"}, 32'(core_rst_n), 32'(m_mode >= 2));
    chk({tag, ".core_ce"}, 32'(core_ce), 32'(m_mode == 2));
  endtask

  task automatic send_byte(logic [7:0] b, int hold = 4);
    if (ena) model_byte(b);
    @(negedge clk);
    byte_in = b;
    byte_stb = 1'b1;
    repeat (hold) @(negedge clk);
    byte_stb = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_program(int n);
    send_byte(8'h4C);
    send_byte(8'(n));
    for (int i = 0; i < 4 * n; i++) send_byte(8'($urandom_range(0, 255)));
    check_outputs("load_done");
  endtask

  initial begin
    logic [7:0] b;
    repeat (10) @(negedge clk);
    chk("rst.imem_we", 32'(imem_we), 0);
    chk("rst.imem_addr", 32'(imem_addr), 0);
    chk("rst.imem_wdata", imem_wdata, 0);
    check_outputs("rst");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // directed two-word program
    send_byte(8'h4C); send_byte(8'h02);
    send_byte(8'h13); send_byte(8'h05); send_byte(8'h10); send_byte(8'h00);
    send_byte(8'h73); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
    check_outputs("prog2");

    // zero and oversized word counts
    send_byte(8'h4C); send_byte(8'h00);
    check_outputs("n0");
    send_byte(8'h52);
    check_outputs("run");
    send_byte(8'h53);
    send_byte(8'h4C); send_byte(8'h11);
    check_outputs("n17");

    // halt then stop
    send_byte(8'h52);
    core_halt = 1'b1;
    repeat (2) @(negedge clk);
    m_mode = 3;
    check_outputs("halt");
    core_halt = 1'b0;
    send_byte(8'h41);
    check_outputs("halt_bad");
    send_byte(8'h53);
    check_outputs("stop");

    // long strobe is one byte; ena=0 discards
    send_byte(8'h4C, 20);
    check_outputs("long_stb");
    send_byte(8'h01, 20);
    check_outputs("long_n");
    for (int i = 0; i < 4; i++) send_byte(8'(8'hA0 + i), 20);
    check_outputs("long_word");
    ena = 1'b0;
    send_byte(8'h52);
    check_outputs("ena0");
    ena = 1'b1;
    repeat (2) @(negedge clk);
    check_outputs("ena1");

    // stop beats halt in the same cycle
    send_byte(8'h52);
    model_byte(8'h53);
    @(negedge clk);
    byte_in = 8'h53;
    byte_stb = 1'b1;
    repeat (2) @(posedge clk);
    #1 core_halt = 1'b1;
    @(negedge clk);
    core_halt = 1'b0;
    byte_stb = 1'b0;
    repeat (4) @(negedge clk);
    check_outputs("stop_wins");

`ifdef LOADSEQ_STEP_EN
    send_byte(8'h54);
    check_outputs("step_enter");
    ce_cnt = 0;
    send_byte(8'h54);
    chk("step_ce_cycles", 32'(ce_cnt), 1);
    check_outputs("step_after");
    send_byte(8'h53);
`else
    send_byte(8'h54);
    check_outputs("t_unknown");
`endif

    // reset mid-load drops the partial word
    send_byte(8'h4C); send_byte(8'h03);
    for (int i = 0; i < 6; i++) send_byte(8'(8'h30 + i));
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst.imem_we", 32'(imem_we), 0);
    check_outputs("midrst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // randomized mix
    for (int it = 0; it < 12; it++) begin
      case ($urandom_range(0, 3))
        0: send_program($urandom_range(1, 16));
        1: begin
          do b = 8'($urandom_range(0, 255));
          while (b == 8'h4C || b == 8'h52 || b == 8'h53 || b == 8'h54);
          send_byte(b);
          check_outputs("junk");
        end
        2: begin
          send_byte(8'h52);
          send_byte(8'h00);
          check_outputs("run_junk");
          send_byte(8'h53);
          check_outputs("run_stop");
        end
        default: send_program(1);
      endcase
    end
    send_program(16);

    repeat (5) @(negedge clk);
    chk("pending_writes", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
